// File: rtl/pipe_stage_skid_reg.sv
// Pipeline register with a valid/ready handshake, an optional two-entry skid buffer,
// synchronous flush and side-effect gating on invalid (bubble) entries.
module pipe_stage_skid_reg #(
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned CTRL_W  = 3,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] aluA_in,
    input  logic [DATA_W-1:0] aluB_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [ADDR_W-1:0] rs1_addr_in,
    input  logic [ADDR_W-1:0] rs2_addr_in,
    input  logic [CTRL_W-1:0] alu_ctrl_in,
    input  logic              reg_wb_in,
    input  logic              mem_we_in,
    input  logic              mem_re_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] aluA_out,
    output logic [DATA_W-1:0] aluB_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [ADDR_W-1:0] rs1_addr_out,
    output logic [ADDR_W-1:0] rs2_addr_out,
    output logic [CTRL_W-1:0] alu_ctrl_out,
    output logic              reg_wb_out,
    output logic              mem_we_out,
    output logic              mem_re_out,
    output logic [1:0]        occupancy
);

    localparam int unsigned EntryW = 3 * DATA_W + 2 * ADDR_W + CTRL_W + 3;

    logic [EntryW-1:0] in_entry;
    logic [EntryW-1:0] main_q, main_d;
    logic              main_valid_q, main_valid_d;
    logic              push, pop;
    logic              main_wb, main_we, main_re;

    assign in_entry = {aluA_in, aluB_in, store_data_in, rs1_addr_in, rs2_addr_in,
                       alu_ctrl_in, reg_wb_in, mem_we_in, mem_re_in};

    assign push = in_valid & in_ready & ~flush;
    assign pop  = main_valid_q & out_ready & ~stall;

    if (SKID_EN) begin : g_skid
        logic [EntryW-1:0] skid_q, skid_d;
        logic              skid_valid_q, skid_valid_d;

        always_comb begin
            main_d       = main_q;
            main_valid_d = main_valid_q;
            skid_d       = skid_q;
            skid_valid_d = skid_valid_q;
            if (flush) begin
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end else if (!main_valid_q) begin
                if (push) begin
                    main_d       = in_entry;
                    main_valid_d = 1'b1;
                end
            end else if (pop) begin
                // A full skid blocks push, so refill from skid never races the input.
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    skid_valid_d = 1'b0;
                end else if (push) begin
                    main_d = in_entry;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (push) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                skid_q       <= '0;
                skid_valid_q <= 1'b0;
            end else begin
                skid_q       <= skid_d;
                skid_valid_q <= skid_valid_d;
            end
        end

        assign in_ready  = ~skid_valid_q;
        assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    end else begin : g_no_skid
        always_comb begin
            main_d       = main_q;
            main_valid_d = main_valid_q;
            if (flush) begin
                main_valid_d = 1'b0;
            end else if (push) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else if (pop) begin
                main_valid_d = 1'b0;
            end
        end

        assign in_ready  = ~main_valid_q | (out_ready & ~stall);
        assign occupancy = {1'b0, main_valid_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
        end
    end

    assign {aluA_out, aluB_out, store_data_out, rs1_addr_out, rs2_addr_out, alu_ctrl_out,
            main_wb, main_we, main_re} = main_q;

    // A bubble must never write the register file or memory.
    assign out_valid  = main_valid_q;
    assign reg_wb_out = main_wb & main_valid_q;
    assign mem_we_out = main_we & main_valid_q;
    assign mem_re_out = main_re & main_valid_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Drives a skid instance (defaults) and a no-skid DATA_W=16 instance with shared stimulus,
// each checked every cycle against a FIFO reference model.
module tb_pipe_stage_skid_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        stall, flush, in_valid, out_ready;
    logic [15:0] a_in, b_in, s_in;
    logic [2:0]  r1_in, r2_in, ctrl_in;
    logic        wb_in, we_in, re_in;

    logic        rdy0, vld0, wb0, we0, re0;
    logic [9:0]  a0, b0, s0;
    logic [2:0]  r1_0, r2_0, c0;
    logic [1:0]  occ0;

    logic        rdy1, vld1, wb1, we1, re1;
    logic [15:0] a1, b1, s1;
    logic [2:0]  r1_1, r2_1, c1;
    logic [1:0]  occ1;

    pipe_stage_skid_reg u_dut_skid (
        .clk(clk), .reset(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0),
        .aluA_in(a_in[9:0]), .aluB_in(b_in[9:0]), .store_data_in(s_in[9:0]),
        .rs1_addr_in(r1_in), .rs2_addr_in(r2_in), .alu_ctrl_in(ctrl_in),
        .reg_wb_in(wb_in), .mem_we_in(we_in), .mem_re_in(re_in),
        .out_valid(vld0), .out_ready(out_ready),
        .aluA_out(a0), .aluB_out(b0), .store_data_out(s0),
        .rs1_addr_out(r1_0), .rs2_addr_out(r2_0), .alu_ctrl_out(c0),
        .reg_wb_out(wb0), .mem_we_out(we0), .mem_re_out(re0), .occupancy(occ0)
    );

    pipe_stage_skid_reg #(.DATA_W(16), .SKID_EN(1'b0)) u_dut_noskid (
        .clk(clk), .reset(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1),
        .aluA_in(a_in), .aluB_in(b_in), .store_data_in(s_in),
        .rs1_addr_in(r1_in), .rs2_addr_in(r2_in), .alu_ctrl_in(ctrl_in),
        .reg_wb_in(wb_in), .mem_we_in(we_in), .mem_re_in(re_in),
        .out_valid(vld1), .out_ready(out_ready),
        .aluA_out(a1), .aluB_out(b1), .store_data_out(s1),
        .rs1_addr_out(r1_1), .rs2_addr_out(r2_1), .alu_ctrl_out(c1),
        .reg_wb_out(wb1), .mem_we_out(we1), .mem_re_out(re1), .occupancy(occ1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: per instance, an ordered list of held entries plus last-shown data.
    logic [63:0] m_ent  [2][2];
    int          m_cnt  [2];
    logic [63:0] m_last [2];

    function automatic logic [63:0] in_entry(input int i);
        if (i == 0)
            return {22'd0, a_in[9:0], b_in[9:0], s_in[9:0], r1_in, r2_in, ctrl_in,
                    wb_in, we_in, re_in};
        return {4'd0, a_in, b_in, s_in, r1_in, r2_in, ctrl_in, wb_in, we_in, re_in};
    endfunction

    function automatic logic exp_ready(input int i);
        if (i == 0) return m_cnt[0] < 2;
        return (m_cnt[1] == 0) || (out_ready && !stall);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_last[i] = '0;
        end
    endtask

    task automatic check_all();
        logic [63:0] obs, vis;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) obs = {22'd0, a0, b0, s0, r1_0, r2_0, c0, wb0, we0, re0};
            else        obs = {4'd0, a1, b1, s1, r1_1, r2_1, c1, wb1, we1, re1};
            vis = (m_cnt[i] > 0) ? m_ent[i][0] : m_last[i];
            check($sformatf("out_valid%0d", i), {63'd0, (i == 0) ? vld0 : vld1},
                  {63'd0, m_cnt[i] > 0});
            check($sformatf("in_ready%0d", i), {63'd0, (i == 0) ? rdy0 : rdy1},
                  {63'd0, exp_ready(i)});
            check($sformatf("occupancy%0d", i), {62'd0, (i == 0) ? occ0 : occ1},
                  64'(m_cnt[i]));
            check($sformatf("fields%0d", i), obs >> 3, vis >> 3);
            check($sformatf("gated_ctrl%0d", i), {61'd0, obs[2:0]},
                  {61'd0, (m_cnt[i] > 0) ? vis[2:0] : 3'b000});
        end
    endtask

    task automatic model_edge();
        bit push, pop;
        for (int i = 0; i < 2; i++) begin
            push = in_valid && exp_ready(i) && !flush;
            pop  = (m_cnt[i] > 0) && out_ready && !stall;
            if (m_cnt[i] > 0) m_last[i] = m_ent[i][0];
            if (flush) begin
                m_cnt[i] = 0;
            end else begin
                if (pop) begin
                    m_ent[i][0] = m_ent[i][1];
                    m_cnt[i]--;
                end
                if (push) begin
                    m_ent[i][m_cnt[i]] = in_entry(i);
                    m_cnt[i]++;
                end
            end
            if (m_cnt[i] > 0) m_last[i] = m_ent[i][0];
        end
    endtask

    task automatic step(input bit iv, input bit ordy, input bit st, input bit fl,
                        input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                        input logic [2:0] ctl);
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        a_in      = a;
        b_in      = b;
        s_in      = 16'($urandom);
        r1_in     = 3'($urandom);
        r2_in     = 3'($urandom);
        ctrl_in   = c;
        {wb_in, we_in, re_in} = ctl;
        #1;
        check_all();
        model_edge();
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, ordy, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 3'b000);
    endtask

    initial begin
        rst_n = 1'b0;
        {stall, flush, in_valid, out_ready} = '0;
        {a_in, b_in, s_in, r1_in, r2_in, ctrl_in, wb_in, we_in, re_in} = '0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Single push with one-cycle latency, then a bubble.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h155, 16'h0AA, 3'b101, 3'b100);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: A, B, C against a blocked sink, then drain in order.
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1, 3'd1, 3'b100);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd2, 3'd2, 3'b010);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd3, 3'd3, 3'b001);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 16'd3, 3'd3, 3'b001);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 16'd3, 3'd3, 3'b001);
        for (int k = 0; k < 3; k++) idle(1'b1);

        // Stall holds a store entry despite out_ready.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h2A, 16'h15, 3'd6, 3'b010);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 3'd0, 3'b000);
        idle(1'b1);
        idle(1'b1);

        // Flush while full, with a simultaneous input.
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h11, 16'h22, 3'd1, 3'b111);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h33, 16'h44, 3'd2, 3'b111);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h55, 16'h66, 3'd3, 3'b111);
        idle(1'b1);

        // Asynchronous reset between edges with the skid stage full.
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h3FF, 16'h3FF, 3'd7, 3'b111);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1FF, 16'h1FF, 3'd7, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", {63'd0, vld0}, 64'd0);
        check("async_occupancy", {62'd0, occ0}, 64'd0);
        check("async_in_ready", {63'd0, rdy0}, 64'd1);
        check("async_fields", {22'd0, a0, b0, s0, r1_0, r2_0, c0, wb0, we0, re0}, 64'd0);
        in_valid = 1'b0;
        flush    = 1'b0;
        model_reset();
        rst_n = 1'b1;
        idle(1'b1);

        // Full-rate streaming, then a blocked sink.
        for (int k = 0; k < 6; k++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 16'(16'hA000 + k), 16'(k), 3'(k), 3'(k));
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'hB000 + k), 16'(k), 3'(k), 3'(k));
        for (int k = 0; k < 3; k++) idle(1'b1);

        // Random traffic with phases of light and heavy backpressure.
        for (int k = 0; k < 600; k++) begin
            int bp;
            bp = ((k / 50) % 2 == 0) ? 30 : 75;
            step($urandom_range(99) < 70, $urandom_range(99) >= bp,
                 $urandom_range(99) < 10, $urandom_range(99) < 5,
                 16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
